// File: rtl/usb_tx_packetizer_if.sv
// Request/byte/PISO bus for usb_tx_packetizer.
//   master: packet source and PISO side (drives start/pid/payload_len/byte_in/byte_valid)
//   slave : packetizer (drives byte_ready, par_ip, load, busy, done, underrun)
interface usb_tx_packetizer_if;
    logic       start;
    logic [3:0] pid;
    logic [6:0] payload_len;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] par_ip;
    logic       load;
    logic       busy;
    logic       done;
    logic       underrun;

    modport master (
        output start, pid, payload_len, byte_in, byte_valid,
        input  byte_ready, par_ip, load, busy, done, underrun
    );

    modport slave (
        input  start, pid, payload_len, byte_in, byte_valid,
        output byte_ready, par_ip, load, busy, done, underrun
    );
endinterface

// File: rtl/usb_tx_packetizer.sv
// USB transmit packetizer: frames SYNC, PID and payload bytes into fixed-length
// byte slots for a downstream parallel-in/serial-out shifter, then a 2-cycle EOP.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   bus.start/pid/payload_len - packet request, latched when accepted in IDLE
//   bus.byte_in/byte_valid/byte_ready - payload byte handshake (byte_ready combinational)
//   bus.par_ip/load - byte to the PISO and its one-cycle load strobe
//   bus.busy/done/underrun - status: in packet, completion pulse, sticky abort
module usb_tx_packetizer #(
    parameter int unsigned SLOT_CLKS = 8,
    parameter int unsigned MAX_LEN   = 64
) (
    input  logic               clk,
    input  logic               rst,
    usb_tx_packetizer_if.slave bus
);

    localparam int unsigned     CNT_W     = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
    localparam int unsigned     LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CLKS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [7:0]       SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       pid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] fetched_q;
    logic [LEN_W-1:0] sent_q;
    logic [7:0]       hold_q;
    logic             hold_full_q;
    logic [7:0]       par_ip_q;
    logic             load_q;
    logic             busy_q;
    logic             done_q;
    logic             underrun_q;
    logic             byte_ready_c;
    logic             xfer;

    assign bus.par_ip   = par_ip_q;
    assign bus.load     = load_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.underrun = underrun_q;
    assign bus.byte_ready = byte_ready_c;

    // Slot counter wraps at the slot length
    assign cnt_next = (cnt_q == SLOT_LAST) ? '0 : cnt_q + CNT_W'(1);

    // Oversized requests silently truncate to MAX_LEN
    assign len_clamped = (32'(bus.payload_len) > MAX_LEN) ? LEN_MAX : LEN_W'(bus.payload_len);

    // Fetch a byte only while framing, into an empty holder, and not past the length
    assign byte_ready_c = ((state_q == PID) || (state_q == DATA)) && !hold_full_q
                          && (fetched_q < len_q);
    assign xfer = bus.byte_valid && byte_ready_c;

    // Packet FSM, holding register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pid_q       <= '0;
            len_q       <= '0;
            fetched_q   <= '0;
            sent_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_ip_q    <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;

            if (xfer) begin
                hold_q      <= bus.byte_in;
                hold_full_q <= 1'b1;
                fetched_q   <= fetched_q + LEN_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= SYNC;
                        cnt_q       <= '0;
                        pid_q       <= bus.pid;
                        len_q       <= len_clamped;
                        fetched_q   <= '0;
                        sent_q      <= '0;
                        hold_full_q <= 1'b0;
                        underrun_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        load_q      <= 1'b1;
                        par_ip_q    <= SYNC_BYTE;
                    end
                end

                SYNC: begin
                    cnt_q <= cnt_next;
                    if (cnt_q == SLOT_LAST) begin
                        state_q  <= PID;
                        load_q   <= 1'b1;
                        par_ip_q <= {~pid_q, pid_q};
                    end
                end

                PID, DATA: begin
                    cnt_q <= cnt_next;
                    if ((state_q == DATA) && (cnt_q == '0) && !load_q) begin
                        // A data slot opened with nothing to send: abort the packet
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        underrun_q <= 1'b1;
                    end else if (cnt_q == SLOT_LAST) begin
                        if (sent_q == len_q) begin
                            state_q <= EOP;
                        end else begin
                            state_q <= DATA;
                            if (hold_full_q) begin
                                load_q      <= 1'b1;
                                par_ip_q    <= hold_q;
                                hold_full_q <= 1'b0;
                                sent_q      <= sent_q + LEN_W'(1);
                            end
                        end
                    end
                end

                EOP: begin
                    // Counter restarted at 0 on entry; second cycle ends EOP
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Scoreboard bench for usb_tx_packetizer: expected PISO loads and done pulses are
// queued when a packet is requested and retired as the DUT produces them.
module tb_usb_tx_packetizer;

    logic clk = 1'b0;
    logic rst;

    usb_tx_packetizer_if bus ();

    usb_tx_packetizer #(
        .SLOT_CLKS(8),
        .MAX_LEN  (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } load_t;

    load_t      exp_load[$];
    int         exp_done[$];
    logic [7:0] src_q[$];
    bit         xfer_pending = 1'b0;
    int         xfer_cnt = 0;
    bit         ready_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Byte source: presents the head of src_q, retires it after a handshake edge
    always @(negedge clk) xfer_pending = bus.byte_valid && bus.byte_ready && !rst;

    always @(posedge clk) begin
        #1;
        if (xfer_pending) begin
            void'(src_q.pop_front());
            xfer_cnt++;
            xfer_pending = 1'b0;
        end
        bus.byte_valid = (src_q.size() != 0);
        bus.byte_in    = (src_q.size() != 0) ? src_q[0] : 8'h00;
    end

    // Output monitor: every load and done must match the head of its queue
    always @(negedge clk) begin : monitor
        load_t e;
        int    dc;
        if (bus.byte_ready) ready_seen = 1'b1;
        if (bus.load) begin
            check("load_expected", 32'(exp_load.size() != 0), 1);
            if (exp_load.size() != 0) begin
                e = exp_load.pop_front();
                check("load_cycle", cyc, e.cyc);
                check("load_par_ip", bus.par_ip, e.val);
            end
        end
        if (bus.done) begin
            check("done_expected", 32'(exp_done.size() != 0), 1);
            if (exp_done.size() != 0) begin
                dc = exp_done.pop_front();
                check("done_cycle", cyc, dc);
            end
            check("done_busy_low", bus.busy, 0);
        end
    end

    task automatic push_exp(input int t0, input logic [3:0] p, input int n_data, input bit with_done);
        load_t e;
        e.cyc = t0 + 1;  e.val = 8'h80;       exp_load.push_back(e);
        e.cyc = t0 + 9;  e.val = {~p, p};     exp_load.push_back(e);
        for (int i = 0; i < n_data; i++) begin
            e.cyc = t0 + 17 + 8 * i;
            e.val = src_q[i];
            exp_load.push_back(e);
        end
        if (with_done) exp_done.push_back(t0 + 1 + 8 * (2 + n_data) + 2);
    endtask

    // Request a packet; start is sampled on the edge ending cycle t0
    task automatic start_pkt(input logic [3:0] p, input logic [6:0] len, input int n_data,
                             input bit with_done, input bit keep_start, output int t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        push_exp(t0, p, n_data, with_done);
        bus.pid         = p;
        bus.payload_len = len;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) bus.start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_load.size() != 0 || exp_done.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(n < budget), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_par_ip"}, bus.par_ip, 0);
        check({tag, "_load"}, bus.load, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_underrun"}, bus.underrun, 0);
        check({tag, "_byte_ready"}, bus.byte_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.start       = 1'b0;
        bus.pid         = '0;
        bus.payload_len = '0;
        bus.byte_valid  = 1'b0;
        bus.byte_in     = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // PID-only ACK packet
        ready_seen = 1'b0;
        start_pkt(4'h2, 7'd0, 0, 1'b1, 1'b0, t0);
        wait_until(t0 + 10);
        check("ack_busy_mid", bus.busy, 1);
        wait_idle(100);
        check("ack_byte_ready_never", 32'(ready_seen), 0);

        // DATA0 with two bytes already waiting
        src_q.push_back(8'hA5);
        src_q.push_back(8'h5A);
        xfer_cnt = 0;
        start_pkt(4'h3, 7'd2, 2, 1'b1, 1'b0, t0);
        wait_idle(100);
        check("data0_transfers", xfer_cnt, 2);

        // Underrun: one byte promised, never supplied
        start_pkt(4'hB, 7'd1, 0, 1'b0, 1'b0, t0);
        wait_until(t0 + 17);
        check("underrun_no_load", bus.load, 0);
        wait_until(t0 + 18);
        check("underrun_flag", bus.underrun, 1);
        check("underrun_busy", bus.busy, 0);
        wait_until(t0 + 40);
        check("underrun_sticky", bus.underrun, 1);
        check("underrun_no_pending", 32'(exp_load.size() + exp_done.size()), 0);
        start_pkt(4'h2, 7'd0, 0, 1'b1, 1'b0, t0);
        wait_until(t0 + 1);
        check("underrun_cleared", bus.underrun, 0);
        wait_idle(100);

        // start held high: second packet only after IDLE is reached
        start_pkt(4'h2, 7'd0, 0, 1'b1, 1'b1, t0);
        push_exp(t0 + 20, 4'h2, 0, 1'b1);
        wait_until(t0 + 20);
        check("held_idle_busy", bus.busy, 0);
        check("held_idle_load", bus.load, 0);
        wait_until(t0 + 22);
        bus.start = 1'b0;
        wait_idle(100);

        // Reset in the PID slot with a byte in the holding register
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        start_pkt(4'h3, 7'd2, 0, 1'b0, 1'b0, t0);
        wait_until(t0 + 12);
        rst = 1'b1;
        wait_until(t0 + 13);
        check_all_zero("midreset");
        rst = 1'b0;
        src_q.delete();
        start_pkt(4'h2, 7'd0, 0, 1'b1, 1'b0, t0);
        wait_idle(100);

        // Oversized length clamps to 64 bytes
        for (int i = 0; i < 66; i++) src_q.push_back(8'($urandom_range(0, 255)));
        xfer_cnt = 0;
        start_pkt(4'h1, 7'd100, 64, 1'b1, 1'b0, t0);
        wait_idle(700);
        check("clamp_transfers", xfer_cnt, 64);
        check("clamp_leftover", src_q.size(), 2);
        src_q.delete();

        repeat (4) @(negedge clk);
        check("final_load_queue", exp_load.size(), 0);
        check("final_done_queue", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_packetizer.md
USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001 SHALL have parameter SLOT_CLKS, default 8: clocks per byte slot, matching the downstream PISO shift length.
REQ-002 SHALL have parameter MAX_LEN, default 64: maximum payload bytes per packet.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  packet request; sampled only in IDLE.
REQ-006 SHALL have port pid  input  4  packet PID nibble; latched on accepted start.
REQ-007 SHALL have port payload_len  input  7  payload byte count (0 = PID-only packet); latched on accepted start.
REQ-008 SHALL have port byte_in  input  8  payload byte from source.
REQ-009 SHALL have port byte_valid  input  1  byte_in valid.
REQ-010 SHALL have port byte_ready  output  1  block can accept byte_in this cycle.
REQ-011 SHALL have port par_ip  output  8  byte to PISO; held stable for the whole slot.
REQ-012 SHALL have port load  output  1  one-cycle PISO load strobe at slot start.
REQ-013 SHALL have port busy  output  1  packet in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse, packet completed.
REQ-015 SHALL have port underrun  output  1  sticky abort flag; cleared on the next accepted start.

Function
REQ-016 All outputs except byte_ready SHALL be registered; byte_ready SHALL be combinational from registered state only.
REQ-017 FSM states SHALL be IDLE, SYNC, PID, DATA, EOP, DONE.
REQ-018 IDLE: start=1 at edge T SHALL go to SYNC, latch pid and min(payload_len, MAX_LEN), clear underrun, and drive load=1 with par_ip=8'h80 in cycle T+1.
REQ-019 Each slot SHALL last SLOT_CLKS cycles; a slot counter SHALL wrap 0..SLOT_CLKS-1, and load SHALL be 1 only when the counter is 0.
REQ-020 SYNC->PID after one slot; the PID slot SHALL carry par_ip={~pid, pid}.
REQ-021 PID->DATA when the latched length is >0; otherwise PID->EOP.
REQ-022 A one-entry holding register SHALL buffer payload; byte_ready=1 iff state is PID or DATA, the holding register is empty, and fetched count < latched length.
REQ-023 A transfer SHALL occur iff byte_valid & byte_ready; fetched count SHALL increment by 1 per transfer.
REQ-024 At each DATA slot start with the holding register full: par_ip<=hold, load=1, holding register emptied, sent count incremented.
REQ-025 At a DATA slot start with the holding register empty: load SHALL stay 0, underrun<=1, state<=IDLE, and done SHALL NOT pulse.
REQ-026 After the slot carrying byte N=latched length: DATA->EOP.
REQ-027 EOP SHALL last 2 cycles with load=0, then go to DONE.
REQ-028 DONE SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-029 busy SHALL be 1 in SYNC, PID, DATA and EOP, and 0 in IDLE and DONE.
REQ-030 start SHALL be ignored in every state except IDLE, including DONE.
REQ-031 payload_len > MAX_LEN SHALL be clamped to MAX_LEN, with no error flag.
REQ-032 par_ip SHALL hold its last value between loads and in EOP/DONE/IDLE.
REQ-033 For a last slot loaded at cycle L, done SHALL pulse at L+SLOT_CLKS+2.

Reset
REQ-034 rst=1 at any edge, including mid-packet, SHALL force IDLE with par_ip=8'h00, load=0, busy=0, done=0 and underrun=0.
REQ-035 rst=1 at any edge SHALL empty the holding register and zero all counters; byte_ready SHALL be 0 in the following cycle.
REQ-036 rst SHALL take priority over start and over any byte transfer in the same cycle.

Verification
REQ-037 ACK, pid=4'h2, len=0, start at T -> load with par_ip 8'h80 at T+1, 8'hD2 at T+9; done at T+19; byte_ready never 1.
REQ-038 DATA0, pid=4'h3, len=2, bytes 8'hA5, 8'h5A available early -> loads at T+1/T+9/T+17/T+25 carrying 80/C3/A5/5A; done at T+35.
REQ-039 len=1 with byte_valid held 0 -> no load at T+17; underrun=1 and busy=0 from T+18; no done pulse; next start clears underrun.
REQ-040 start held high through a whole packet -> exactly one packet sent, start in DONE ignored, second packet starts only after IDLE is reached.
REQ-041 rst pulsed at T+12 during the PID slot -> all outputs 0 on the next cycle; a following len=0 packet matches REQ-037 timing.
REQ-042 payload_len=100 -> exactly 64 transfers and 64 data loads; done at T+17+8*63+10.
